// File: rtl/cpu_control_pkg.sv
// RV32I control types: opcodes, funct3 encodings, mux selects, ALU ops and FSM states.
// Also holds the per-state default control word so every state starts from the same baseline.
package cpu_control_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        add  = 3'b000,
        sll  = 3'b001,
        slt  = 3'b010,
        sltu = 3'b011,
        axor = 3'b100,
        sr   = 3'b101,
        aor  = 3'b110,
        aand = 3'b111
    } arith_funct3_t;

    // Encoding chosen so that funct3 of an arithmetic op casts directly to its ALU op.
    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [1:0] {PCMUX_PC_PLUS4, PCMUX_ALU_OUT, PCMUX_ALU_MOD2} pcmux_sel_t;
    typedef enum logic {ALUMUX1_RS1_OUT, ALUMUX1_PC_OUT} alumux1_sel_t;
    typedef enum logic [2:0] {
        ALUMUX2_I_IMM, ALUMUX2_U_IMM, ALUMUX2_B_IMM, ALUMUX2_S_IMM, ALUMUX2_J_IMM, ALUMUX2_RS2_OUT
    } alumux2_sel_t;
    typedef enum logic [3:0] {
        RFMUX_ALU_OUT, RFMUX_BR_EN, RFMUX_U_IMM, RFMUX_LW, RFMUX_PC_PLUS4,
        RFMUX_LB, RFMUX_LBU, RFMUX_LH, RFMUX_LHU
    } regfilemux_sel_t;
    typedef enum logic {MARMUX_PC_OUT, MARMUX_ALU_OUT} marmux_sel_t;
    typedef enum logic {CMPMUX_RS2_OUT, CMPMUX_I_IMM} cmpmux_sel_t;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC,
        BR, JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2
    } cpu_state_t;

    typedef struct packed {
        pcmux_sel_t      pcmux_sel;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        regfilemux_sel_t regfilemux_sel;
        marmux_sel_t     marmux_sel;
        cmpmux_sel_t     cmpmux_sel;
        logic            load_pc;
        logic            load_ir;
        logic            load_regfile;
        logic            load_mar;
        logic            load_mdr;
        logic            load_data_out;
        alu_ops          aluop;
        branch_funct3_t  cmpop;
        logic            mem_read;
        logic            mem_write;
    } ctrl_t;

    function automatic ctrl_t ctrl_defaults(input logic [2:0] funct3);
        ctrl_t c;
        c.pcmux_sel      = PCMUX_PC_PLUS4;
        c.alumux1_sel    = ALUMUX1_RS1_OUT;
        c.alumux2_sel    = ALUMUX2_I_IMM;
        c.regfilemux_sel = RFMUX_ALU_OUT;
        c.marmux_sel     = MARMUX_PC_OUT;
        c.cmpmux_sel     = CMPMUX_RS2_OUT;
        c.load_pc        = 1'b0;
        c.load_ir        = 1'b0;
        c.load_regfile   = 1'b0;
        c.load_mar       = 1'b0;
        c.load_mdr       = 1'b0;
        c.load_data_out  = 1'b0;
        c.aluop          = alu_ops'(funct3);
        c.cmpop          = branch_funct3_t'(funct3);
        c.mem_read       = 1'b0;
        c.mem_write      = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Control <-> datapath/memory bundle: IR fields and status in, selects/loads/strobes out.
// master = control FSM side, slave = datapath and memory side.
interface cpu_control_if import cpu_control_pkg::*; ();
    rv32i_opcode     opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            br_en;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [1:0]      mar_byte_request;
    logic            mem_resp;

    pcmux_sel_t      pcmux_sel;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    marmux_sel_t     marmux_sel;
    cmpmux_sel_t     cmpmux_sel;
    logic            load_pc;
    logic            load_ir;
    logic            load_regfile;
    logic            load_mar;
    logic            load_mdr;
    logic            load_data_out;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    logic            mem_read;
    logic            mem_write;
    logic [3:0]      mem_byte_enable;

    modport master (
        input  opcode, funct3, funct7, br_en, rs1, rs2, mar_byte_request, mem_resp,
        output pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel,
        output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
        output aluop, cmpop, mem_read, mem_write, mem_byte_enable
    );

    modport slave (
        output opcode, funct3, funct7, br_en, rs1, rs2, mar_byte_request, mem_resp,
        input  pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel,
        input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
        input  aluop, cmpop, mem_read, mem_write, mem_byte_enable
    );
endinterface

// File: rtl/cpu_control_mem_be_gen.sv
// Store lane mask from funct3 and the byte offset of the access; purely combinational.
// Misaligned halfword/word offsets are not corrected: sh uses only offset[1], sw is always all lanes.
module mem_be_gen import cpu_control_pkg::*; (
    input  logic [2:0] funct3,
    input  logic [1:0] mar_byte_request,
    output logic [3:0] mem_byte_enable
);

    always_comb begin
        mem_byte_enable = 4'hF;
        case (store_funct3_t'(funct3))
            sb:      mem_byte_enable = 4'h1 << mar_byte_request;
            sh:      mem_byte_enable = 4'h3 << {mar_byte_request[1], 1'b0};
            default: mem_byte_enable = 4'hF;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// Multicycle RV32I control FSM; outputs are combinational from state and IR fields.
// ALU/LUI/branch/jump take 5 cycles, loads and stores 7, plus one per cycle mem_resp is withheld.
module cpu_control import cpu_control_pkg::*; (
    input  logic          clk,
    input  logic          rst,
    cpu_control_if.master ctl
);

    cpu_state_t state_q;
    cpu_state_t state_d;
    ctrl_t      ctrl_c;
    logic [3:0] st_be;

    mem_be_gen u_be_gen (
        .funct3           (ctl.funct3),
        .mar_byte_request (ctl.mar_byte_request),
        .mem_byte_enable  (st_be)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH1:    state_d = FETCH2;
            FETCH2:    if (ctl.mem_resp) state_d = FETCH3;
            FETCH3:    state_d = DECODE;
            DECODE: begin
                case (ctl.opcode)
                    op_imm:   state_d = IMM;
                    op_reg:   state_d = REG;
                    op_lui:   state_d = LUI;
                    op_auipc: state_d = AUIPC;
                    op_br:    state_d = BR;
                    op_jal:   state_d = JAL;
                    op_jalr:  state_d = JALR;
                    op_load,
                    op_store: state_d = CALC_ADDR;
                    default:  state_d = FETCH1;
                endcase
            end
            CALC_ADDR: state_d = (ctl.opcode == op_store) ? ST1 : LD1;
            LD1:       if (ctl.mem_resp) state_d = LD2;
            ST1:       if (ctl.mem_resp) state_d = ST2;
            default:   state_d = FETCH1;
        endcase
    end

    always_comb begin
        ctrl_c = ctrl_defaults(ctl.funct3);
        case (state_q)
            FETCH1: ctrl_c.load_mar = 1'b1;
            FETCH2: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.load_mdr = 1'b1;
            end
            FETCH3: ctrl_c.load_ir = 1'b1;
            DECODE: begin
                case (ctl.opcode)
                    op_imm, op_reg, op_lui, op_auipc, op_br,
                    op_jal, op_jalr, op_load, op_store: ctrl_c.load_pc = 1'b0;
                    default:                            ctrl_c.load_pc = 1'b1;
                endcase
            end
            IMM: begin
                ctrl_c.load_pc      = 1'b1;
                ctrl_c.load_regfile = 1'b1;
                case (arith_funct3_t'(ctl.funct3))
                    slt: begin
                        ctrl_c.cmpmux_sel     = CMPMUX_I_IMM;
                        ctrl_c.cmpop          = blt;
                        ctrl_c.regfilemux_sel = RFMUX_BR_EN;
                    end
                    sltu: begin
                        ctrl_c.cmpmux_sel     = CMPMUX_I_IMM;
                        ctrl_c.cmpop          = bltu;
                        ctrl_c.regfilemux_sel = RFMUX_BR_EN;
                    end
                    sr:      ctrl_c.aluop = ctl.funct7[5] ? alu_sra : alu_srl;
                    default: ctrl_c.aluop = alu_ops'(ctl.funct3);
                endcase
            end
            REG: begin
                ctrl_c.load_pc      = 1'b1;
                ctrl_c.load_regfile = 1'b1;
                ctrl_c.alumux2_sel  = ALUMUX2_RS2_OUT;
                case (arith_funct3_t'(ctl.funct3))
                    add: ctrl_c.aluop = ctl.funct7[5] ? alu_sub : alu_add;
                    sr:  ctrl_c.aluop = ctl.funct7[5] ? alu_sra : alu_srl;
                    slt: begin
                        ctrl_c.cmpop          = blt;
                        ctrl_c.cmpmux_sel     = CMPMUX_RS2_OUT;
                        ctrl_c.regfilemux_sel = RFMUX_BR_EN;
                    end
                    sltu: begin
                        ctrl_c.cmpop          = bltu;
                        ctrl_c.cmpmux_sel     = CMPMUX_RS2_OUT;
                        ctrl_c.regfilemux_sel = RFMUX_BR_EN;
                    end
                    default: ctrl_c.aluop = alu_ops'(ctl.funct3);
                endcase
            end
            LUI: begin
                ctrl_c.load_pc        = 1'b1;
                ctrl_c.load_regfile   = 1'b1;
                ctrl_c.regfilemux_sel = RFMUX_U_IMM;
            end
            AUIPC: begin
                ctrl_c.load_pc      = 1'b1;
                ctrl_c.load_regfile = 1'b1;
                ctrl_c.alumux1_sel  = ALUMUX1_PC_OUT;
                ctrl_c.alumux2_sel  = ALUMUX2_U_IMM;
                ctrl_c.aluop        = alu_add;
            end
            BR: begin
                ctrl_c.load_pc     = 1'b1;
                ctrl_c.alumux1_sel = ALUMUX1_PC_OUT;
                ctrl_c.alumux2_sel = ALUMUX2_B_IMM;
                ctrl_c.aluop       = alu_add;
                ctrl_c.pcmux_sel   = ctl.br_en ? PCMUX_ALU_OUT : PCMUX_PC_PLUS4;
            end
            JAL, JALR: begin
                // rd takes PC+4 from the still-unloaded PC, so rd==rs1 on JALR is safe.
                ctrl_c.load_pc        = 1'b1;
                ctrl_c.load_regfile   = 1'b1;
                ctrl_c.regfilemux_sel = RFMUX_PC_PLUS4;
                ctrl_c.aluop          = alu_add;
                ctrl_c.pcmux_sel      = PCMUX_ALU_MOD2;
                ctrl_c.alumux1_sel    = (state_q == JAL) ? ALUMUX1_PC_OUT : ALUMUX1_RS1_OUT;
                ctrl_c.alumux2_sel    = (state_q == JAL) ? ALUMUX2_J_IMM : ALUMUX2_I_IMM;
            end
            CALC_ADDR: begin
                ctrl_c.aluop      = alu_add;
                ctrl_c.marmux_sel = MARMUX_ALU_OUT;
                ctrl_c.load_mar   = 1'b1;
                if (ctl.opcode == op_store) begin
                    ctrl_c.alumux2_sel   = ALUMUX2_S_IMM;
                    ctrl_c.load_data_out = 1'b1;
                end
            end
            LD1: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.load_mdr = 1'b1;
            end
            LD2: begin
                ctrl_c.load_pc      = 1'b1;
                ctrl_c.load_regfile = 1'b1;
                case (load_funct3_t'(ctl.funct3))
                    lb:      ctrl_c.regfilemux_sel = RFMUX_LB;
                    lh:      ctrl_c.regfilemux_sel = RFMUX_LH;
                    lbu:     ctrl_c.regfilemux_sel = RFMUX_LBU;
                    lhu:     ctrl_c.regfilemux_sel = RFMUX_LHU;
                    default: ctrl_c.regfilemux_sel = RFMUX_LW;
                endcase
            end
            ST1:     ctrl_c.mem_write = 1'b1;
            ST2:     ctrl_c.load_pc   = 1'b1;
            default: ctrl_c.load_pc   = 1'b0;
        endcase
    end

    assign ctl.pcmux_sel       = ctrl_c.pcmux_sel;
    assign ctl.alumux1_sel     = ctrl_c.alumux1_sel;
    assign ctl.alumux2_sel     = ctrl_c.alumux2_sel;
    assign ctl.regfilemux_sel  = ctrl_c.regfilemux_sel;
    assign ctl.marmux_sel      = ctrl_c.marmux_sel;
    assign ctl.cmpmux_sel      = ctrl_c.cmpmux_sel;
    assign ctl.load_pc         = ctrl_c.load_pc;
    assign ctl.load_ir         = ctrl_c.load_ir;
    assign ctl.load_regfile    = ctrl_c.load_regfile;
    assign ctl.load_mar        = ctrl_c.load_mar;
    assign ctl.load_mdr        = ctrl_c.load_mdr;
    assign ctl.load_data_out   = ctrl_c.load_data_out;
    assign ctl.aluop           = ctrl_c.aluop;
    assign ctl.cmpop           = ctrl_c.cmpop;
    assign ctl.mem_read        = ctrl_c.mem_read;
    assign ctl.mem_write       = ctrl_c.mem_write;
    assign ctl.mem_byte_enable = (state_q == ST1) ? st_be : 4'hF;

endmodule

// File: tb/tb_cpu_control.sv
// Directed-vector bench for cpu_control: walks instructions through the FSM and
// compares state and control outputs against hand-computed values.
module tb_cpu_control;
    import cpu_control_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cpu_control_if bus ();

    cpu_control dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts in FETCH1, returns in DECODE; memory answers in the first FETCH2 cycle.
    task automatic fetch_to_decode(input rv32i_opcode op, input logic [2:0] f3, input logic [6:0] f7);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.mem_resp = 1'b1;
        #1;
        chk("fetch1_state", dut.state_q, FETCH1);
        chk("fetch1_load_mar", bus.load_mar, 1'b1);
        tick();
        chk("fetch2_state", dut.state_q, FETCH2);
        chk("fetch2_mem_read", bus.mem_read, 1'b1);
        chk("fetch2_load_mdr", bus.load_mdr, 1'b1);
        tick();
        bus.mem_resp = 1'b0;
        #1;
        chk("fetch3_state", dut.state_q, FETCH3);
        chk("fetch3_load_ir", bus.load_ir, 1'b1);
        tick();
        chk("decode_state", dut.state_q, DECODE);
    endtask

    task automatic store_seq(input string tag, input logic [2:0] f3, input logic [1:0] off,
                             input logic [3:0] exp_be);
        fetch_to_decode(op_store, f3, 7'h00);
        tick();
        bus.mar_byte_request = off;
        #1;
        chk({tag, "_calc_data_out"}, bus.load_data_out, 1'b1);
        chk({tag, "_calc_be_idle"}, bus.mem_byte_enable, 4'hF);
        tick();
        chk({tag, "_st1_write"}, bus.mem_write, 1'b1);
        chk({tag, "_st1_be"}, bus.mem_byte_enable, exp_be);
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        #1;
        chk({tag, "_st2_state"}, dut.state_q, ST2);
        chk({tag, "_st2_write"}, bus.mem_write, 1'b0);
        chk({tag, "_st2_load_pc"}, bus.load_pc, 1'b1);
        tick();
    endtask

    initial begin
        rst                  = 1'b1;
        bus.opcode           = op_imm;
        bus.funct3           = 3'b000;
        bus.funct7           = 7'h00;
        bus.br_en            = 1'b0;
        bus.rs1              = 5'd0;
        bus.rs2              = 5'd0;
        bus.mar_byte_request = 2'd0;
        bus.mem_resp         = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state: defaults plus load_mar
        chk("rst_state", dut.state_q, FETCH1);
        chk("rst_load_mar", bus.load_mar, 1'b1);
        chk("rst_mem_read", bus.mem_read, 1'b0);
        chk("rst_load_pc", bus.load_pc, 1'b0);
        chk("rst_be", bus.mem_byte_enable, 4'hF);
        chk("rst_pcmux", bus.pcmux_sel, PCMUX_PC_PLUS4);
        chk("rst_marmux", bus.marmux_sel, MARMUX_PC_OUT);
        chk("rst_alumux2", bus.alumux2_sel, ALUMUX2_I_IMM);

        // addi x1,x0,5: five cycles back to FETCH1
        bus.rs1 = 5'd0;
        fetch_to_decode(op_imm, 3'b000, 7'h00);
        chk("addi_decode_load_pc", bus.load_pc, 1'b0);
        chk("addi_decode_load_rf", bus.load_regfile, 1'b0);
        tick();
        chk("addi_state", dut.state_q, IMM);
        chk("addi_load_rf", bus.load_regfile, 1'b1);
        chk("addi_load_pc", bus.load_pc, 1'b1);
        chk("addi_aluop", bus.aluop, alu_add);
        chk("addi_rfmux", bus.regfilemux_sel, RFMUX_ALU_OUT);
        tick();
        chk("addi_back_fetch1", dut.state_q, FETCH1);

        // beq taken / not taken
        fetch_to_decode(op_br, 3'b000, 7'h00);
        bus.br_en = 1'b1;
        tick();
        chk("beq_state", dut.state_q, BR);
        chk("beq_taken_pcmux", bus.pcmux_sel, PCMUX_ALU_OUT);
        chk("beq_load_rf", bus.load_regfile, 1'b0);
        chk("beq_alumux2", bus.alumux2_sel, ALUMUX2_B_IMM);
        chk("beq_cmpop", bus.cmpop, beq);
        bus.br_en = 1'b0;
        #1;
        chk("beq_not_taken_pcmux", bus.pcmux_sel, PCMUX_PC_PLUS4);
        chk("beq_load_pc", bus.load_pc, 1'b1);
        tick();

        // Store lane masks
        store_seq("sb3", 3'b000, 2'd3, 4'b1000);
        store_seq("sh2", 3'b001, 2'd2, 4'b1100);
        store_seq("sw0", 3'b010, 2'd0, 4'hF);

        // lw with mem_resp held off for two cycles
        fetch_to_decode(op_load, 3'b010, 7'h00);
        tick();
        chk("lw_calc_state", dut.state_q, CALC_ADDR);
        chk("lw_calc_load_mar", bus.load_mar, 1'b1);
        chk("lw_calc_marmux", bus.marmux_sel, MARMUX_ALU_OUT);
        chk("lw_calc_data_out", bus.load_data_out, 1'b0);
        chk("lw_calc_load_pc", bus.load_pc, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) bus.mem_resp = 1'b1;
            chk("lw_ld1_state", dut.state_q, LD1);
            chk("lw_ld1_mem_read", bus.mem_read, 1'b1);
            chk("lw_ld1_load_mdr", bus.load_mdr, 1'b1);
        end
        tick();
        bus.mem_resp = 1'b0;
        #1;
        chk("lw_ld2_state", dut.state_q, LD2);
        chk("lw_ld2_mem_read", bus.mem_read, 1'b0);
        chk("lw_ld2_rfmux", bus.regfilemux_sel, RFMUX_LW);
        chk("lw_ld2_load_rf", bus.load_regfile, 1'b1);
        tick();

        // Arithmetic decode variants
        fetch_to_decode(op_reg, 3'b000, 7'h20);
        tick();
        chk("sub_aluop", bus.aluop, alu_sub);
        chk("sub_alumux2", bus.alumux2_sel, ALUMUX2_RS2_OUT);
        tick();
        fetch_to_decode(op_imm, 3'b101, 7'h20);
        tick();
        chk("srai_aluop", bus.aluop, alu_sra);
        tick();
        fetch_to_decode(op_imm, 3'b101, 7'h00);
        tick();
        chk("srli_aluop", bus.aluop, alu_srl);
        tick();
        fetch_to_decode(op_reg, 3'b011, 7'h00);
        tick();
        chk("sltu_rfmux", bus.regfilemux_sel, RFMUX_BR_EN);
        chk("sltu_cmpop", bus.cmpop, bltu);
        chk("sltu_cmpmux", bus.cmpmux_sel, CMPMUX_RS2_OUT);
        tick();
        fetch_to_decode(op_imm, 3'b010, 7'h00);
        tick();
        chk("slti_cmpmux", bus.cmpmux_sel, CMPMUX_I_IMM);
        chk("slti_cmpop", bus.cmpop, blt);
        tick();

        // jal
        fetch_to_decode(op_jal, 3'b000, 7'h00);
        tick();
        chk("jal_pcmux", bus.pcmux_sel, PCMUX_ALU_MOD2);
        chk("jal_rfmux", bus.regfilemux_sel, RFMUX_PC_PLUS4);
        chk("jal_alumux1", bus.alumux1_sel, ALUMUX1_PC_OUT);
        tick();

        // Reset during LD1 with a response pending
        fetch_to_decode(op_load, 3'b010, 7'h00);
        tick();
        tick();
        chk("rstld_in_ld1", dut.state_q, LD1);
        rst          = 1'b1;
        bus.mem_resp = 1'b1;
        tick();
        rst          = 1'b0;
        bus.mem_resp = 1'b0;
        #1;
        chk("rstld_state", dut.state_q, FETCH1);
        chk("rstld_mem_read", bus.mem_read, 1'b0);
        chk("rstld_load_mar", bus.load_mar, 1'b1);

        // Illegal opcode: DECODE loads PC only, then FETCH1
        fetch_to_decode(rv32i_opcode'(7'h00), 3'b000, 7'h00);
        chk("ill_load_pc", bus.load_pc, 1'b1);
        chk("ill_load_rf", bus.load_regfile, 1'b0);
        chk("ill_load_mar", bus.load_mar, 1'b0);
        chk("ill_mem_read", bus.mem_read, 1'b0);
        tick();
        chk("ill_back_fetch1", dut.state_q, FETCH1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
